// File: rtl/mem_refill_arbiter_if.sv
// Cache-refill and main-memory block-port signal bundle for mem_refill_arbiter.
// master = arbiter side, slave = caches plus memory model.
interface mem_refill_arbiter_if;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned BLK_W  = 128;

    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic [BLK_W-1:0]  i_data;
    logic              i_done;
    logic              i_err;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [BLK_W-1:0]  d_wdata;
    logic [BLK_W-1:0]  d_data;
    logic              d_done;
    logic              d_err;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [BLK_W-1:0]  mem_wdata;
    logic              mem_ack;
    logic [BLK_W-1:0]  mem_rdata;

    modport master (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_ack, mem_rdata,
        output i_data, i_done, i_err, d_data, d_done, d_err,
        output mem_req, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_ack, mem_rdata,
        input  i_data, i_done, i_err, d_data, d_done, d_err,
        input  mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_refill_arbiter.sv
// Arbitrates ICache/DCache block requests onto one memory port with a timeout watchdog.
// Define ARB_ROUND_ROBIN_EN for round-robin ties; default is DCache-wins fixed priority.
module mem_refill_arbiter #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    mem_refill_arbiter_if.master bus
);
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned BLK_W  = 128;
    localparam int unsigned CNT_W  = 8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state, state_n;
    logic             sel, sel_n;
    logic             last, last_n;
    logic [CNT_W-1:0] cnt, cnt_n;

    logic              mem_req, mem_req_n;
    logic              mem_we, mem_we_n;
    logic [ADDR_W-1:0] mem_addr, mem_addr_n;
    logic [BLK_W-1:0]  mem_wdata, mem_wdata_n;
    logic [BLK_W-1:0]  i_data, i_data_n;
    logic [BLK_W-1:0]  d_data, d_data_n;
    logic              i_done, i_done_n;
    logic              i_err, i_err_n;
    logic              d_done, d_done_n;
    logic              d_err, d_err_n;

    logic              grant_d_c;
    logic [ADDR_W-1:0] addr_c;

    // Tie-break between simultaneous requests
    always_comb begin
        grant_d_c = bus.d_req;
        if (bus.i_req && bus.d_req) begin
`ifdef ARB_ROUND_ROBIN_EN
            grant_d_c = ~last;
`else
            grant_d_c = 1'b1;
`endif
        end
        addr_c = grant_d_c ? bus.d_addr : bus.i_addr;
    end

    // Next-state and next-output logic; pulses and return data default to zero
    always_comb begin
        state_n     = state;
        sel_n       = sel;
        last_n      = last;
        cnt_n       = cnt;
        mem_req_n   = mem_req;
        mem_we_n    = mem_we;
        mem_addr_n  = mem_addr;
        mem_wdata_n = mem_wdata;
        i_data_n    = '0;
        d_data_n    = '0;
        i_done_n    = 1'b0;
        i_err_n     = 1'b0;
        d_done_n    = 1'b0;
        d_err_n     = 1'b0;

        case (state)
            S_IDLE: begin
                if (bus.i_req || bus.d_req) begin
                    state_n     = S_BUSY;
                    sel_n       = grant_d_c;
                    cnt_n       = '0;
                    mem_req_n   = 1'b1;
                    mem_we_n    = grant_d_c & bus.d_we;
                    mem_addr_n  = addr_c & ~ADDR_W'(32'hF);
                    mem_wdata_n = grant_d_c ? bus.d_wdata : '0;
                end
            end
            S_BUSY: begin
                if (bus.mem_ack || (cnt == CNT_LAST)) begin
                    state_n     = S_DONE;
                    last_n      = sel;
                    mem_req_n   = 1'b0;
                    mem_we_n    = 1'b0;
                    mem_addr_n  = '0;
                    mem_wdata_n = '0;
                    // Ack wins over a simultaneous watchdog expiry
                    if (bus.mem_ack) begin
                        if (sel) begin
                            d_done_n = 1'b1;
                            d_data_n = mem_we ? '0 : bus.mem_rdata;
                        end else begin
                            i_done_n = 1'b1;
                            i_data_n = bus.mem_rdata;
                        end
                    end else begin
                        d_err_n = sel;
                        i_err_n = ~sel;
                    end
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            S_DONE: begin
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            sel       <= 1'b0;
            last      <= 1'b1;
            cnt       <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            i_data    <= '0;
            d_data    <= '0;
            i_done    <= 1'b0;
            i_err     <= 1'b0;
            d_done    <= 1'b0;
            d_err     <= 1'b0;
        end else begin
            state     <= state_n;
            sel       <= sel_n;
            last      <= last_n;
            cnt       <= cnt_n;
            mem_req   <= mem_req_n;
            mem_we    <= mem_we_n;
            mem_addr  <= mem_addr_n;
            mem_wdata <= mem_wdata_n;
            i_data    <= i_data_n;
            d_data    <= d_data_n;
            i_done    <= i_done_n;
            i_err     <= i_err_n;
            d_done    <= d_done_n;
            d_err     <= d_err_n;
        end
    end

    assign bus.mem_req   = mem_req;
    assign bus.mem_we    = mem_we;
    assign bus.mem_addr  = mem_addr;
    assign bus.mem_wdata = mem_wdata;
    assign bus.i_data    = i_data;
    assign bus.d_data    = d_data;
    assign bus.i_done    = i_done;
    assign bus.i_err     = i_err;
    assign bus.d_done    = d_done;
    assign bus.d_err     = d_err;

endmodule
